// File: rtl/im_pkg.sv
// Shared types and constants for the instruction memory: boot image,
// alignment width and the output-hold state encoding.
package im_pkg;

    localparam int unsigned IM_ALIGN_BITS = 2;
    localparam int unsigned IM_BOOT_WORDS = 16;
    localparam int unsigned IM_BOOT_W     = 32;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    localparam logic [IM_BOOT_W-1:0] IM_BOOT [IM_BOOT_WORDS] = '{
        0:       32'hD66A0000,
        1:       32'h98EA0000,
        7:       32'h0000F385,
        default: 32'h00000000
    };

    // Boot word for any memory index; words past the image boot to zero.
    function automatic logic [IM_BOOT_W-1:0] im_boot_word(input int unsigned idx);
        logic [IM_BOOT_W-1:0] word;
        word = '0;
        if (idx < IM_BOOT_WORDS) begin
            word = IM_BOOT[4'(idx)];
        end
        return word;
    endfunction

endpackage

// File: rtl/im_out_hold.sv
// One-entry valid/ready holding register (EMPTY/FULL). Lets the consumer
// stall without losing the held word; updates on the falling clock edge.
module im_out_hold
    import im_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready_c,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);

    hold_state_e r_state;
    hold_state_e w_state_nxt;
    logic        w_accept;
    logic [W-1:0] r_data;

    assign w_accept = i_in_valid && o_in_ready_c;

    always_ff @(negedge clk) begin
        if (!i_rst_n) begin
            r_state <= HOLD_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOLD_EMPTY: if (w_accept) w_state_nxt = HOLD_FULL;
            HOLD_FULL:  if (i_out_ready && !w_accept) w_state_nxt = HOLD_EMPTY;
            default:    w_state_nxt = HOLD_EMPTY;
        endcase
    end

    // Ready never looks at i_in_valid, so no valid->ready combinational loop.
    always_comb begin
        o_out_valid  = 1'b0;
        o_in_ready_c = 1'b1;
        o_out_valid  = (r_state == HOLD_FULL);
        o_in_ready_c = (r_state == HOLD_EMPTY) || i_out_ready;
    end

    always_ff @(negedge clk) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= i_in_data;
        end
    end

    assign o_out_data = r_data;

endmodule

// File: rtl/im_mem_fetch.sv
// Instruction memory with a registered valid/ready fetch port and an
// auto-incrementing program-load port; contents reboot to IM_BOOT on reset.
module im_mem_fetch
    import im_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] IR,
    output logic              resp_err,
    input  logic              load_start,
    input  logic [AW-1:0]     load_addr,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic [AW-1:0]     load_ptr
);

    localparam int unsigned HOLD_W = DATA_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_load_ptr;

    logic [AW-1:0]     w_idx;
    logic [AW-1:0]     w_wr_idx;
    logic              w_err;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_fetch_word;
    logic [HOLD_W-1:0] w_hold_out;

    assign w_idx    = pc[AW+IM_ALIGN_BITS-1:IM_ALIGN_BITS];
    assign w_err    = (pc[IM_ALIGN_BITS-1:0] != '0) ||
                      ((pc >> (AW + IM_ALIGN_BITS)) != 32'd0);
    assign w_wr_idx = load_start ? load_addr : r_load_ptr;

    // Write-first: a same-edge load to the fetched word bypasses the array.
    assign w_rd_word    = (load_valid && (w_wr_idx == w_idx)) ? load_data : r_mem[w_idx];
    assign w_fetch_word = w_err ? '0 : w_rd_word;

    always_ff @(negedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(im_boot_word(i));
            end
        end else if (load_valid) begin
            r_mem[w_wr_idx] <= load_data;
        end
    end

    // Pointer wraps naturally at DEPTH since DEPTH is a power of two.
    always_ff @(negedge clk) begin
        if (!reset) begin
            r_load_ptr <= '0;
        end else if (load_start) begin
            r_load_ptr <= load_valid ? AW'(load_addr + AW'(1)) : load_addr;
        end else if (load_valid) begin
            r_load_ptr <= AW'(r_load_ptr + AW'(1));
        end
    end

    assign load_ptr = r_load_ptr;

    im_out_hold #(
        .W (HOLD_W)
    ) u_out_hold (
        .clk          (clk),
        .i_rst_n      (reset),
        .i_in_valid   (req_valid),
        .o_in_ready_c (req_ready),
        .i_in_data    ({w_err, w_fetch_word}),
        .o_out_valid  (resp_valid),
        .i_out_ready  (resp_ready),
        .o_out_data   (w_hold_out)
    );

    assign resp_err = w_hold_out[HOLD_W-1];
    assign IR       = w_hold_out[DATA_W-1:0];

endmodule

// File: tb/tb_im_mem_fetch.sv
// Scoreboard bench for im_mem_fetch: the driver runs a word-level memory model
// and queues expected responses; a monitor pops and compares on every take.
module tb_im_mem_fetch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned QLEN = 4096;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       pc;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] IR;
    logic              resp_err;
    logic              load_start;
    logic [AW-1:0]     load_addr;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic [AW-1:0]     load_ptr;

    im_mem_fetch #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .pc         (pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .IR         (IR),
        .resp_err   (resp_err),
        .load_start (load_start),
        .load_addr  (load_addr),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ptr   (load_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state (owned by the driver)
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    bit                mdl_full;
    int unsigned       mdl_ptr;
    logic [DATA_W:0]   exp_q [QLEN];
    int unsigned       wr_cnt;
    bit                exp_req_ready;
    bit                exp_resp_valid;
    logic [AW-1:0]     exp_ptr;
    bit                exp_post_rst;
    bit                prev_rst;
    bit                end_chk;
    bit                mon_en;

    // Checking state (owned by the monitor)
    int unsigned       rd_cnt;
    int                n_cmp;
    int                n_bad;

    function automatic logic [DATA_W-1:0] boot_val(input int unsigned i);
        case (i)
            0:       return DATA_W'(32'hD66A0000);
            1:       return DATA_W'(32'h98EA0000);
            7:       return DATA_W'(32'h0000F385);
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive after the active (falling) edge, update the model.
    task automatic step(input bit rn, input bit rv, input logic [31:0] pcv, input bit rr,
                        input bit ls, input logic [AW-1:0] la, input bit lv,
                        input logic [DATA_W-1:0] ld);
        int unsigned widx;
        bit          acc;
        bit          err;
        @(negedge clk);
        #1;
        reset      = rn;
        req_valid  = rv;
        pc         = pcv;
        resp_ready = rr;
        load_start = ls;
        load_addr  = la;
        load_valid = lv;
        load_data  = ld;
        exp_post_rst = prev_rst;
        prev_rst     = !rn;
        if (!rn) begin
            mdl_full = 1'b0;
            mdl_ptr  = 0;
            for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = boot_val(i);
        end else begin
            exp_resp_valid = mdl_full;
            exp_req_ready  = !mdl_full || rr;
            exp_ptr        = AW'(mdl_ptr);
            acc  = rv && exp_req_ready;
            widx = ls ? int'(la) : mdl_ptr;
            if (lv) mdl_mem[widx] = ld;
            if (acc) begin
                err = (pcv % 4 != 0) || ({32'd0, pcv} >= 64'(DEPTH) * 64'd4);
                exp_q[wr_cnt % QLEN] = {err, err ? {DATA_W{1'b0}} : mdl_mem[pcv / 4 % DEPTH]};
                wr_cnt++;
            end
            mdl_full = acc || (mdl_full && !rr);
            if (ls) mdl_ptr = (int'(la) + (lv ? 1 : 0)) % DEPTH;
            else if (lv) mdl_ptr = (mdl_ptr + 1) % DEPTH;
        end
    endtask

    task automatic fetch(input logic [31:0] pcv, input bit rr);
        step(1'b1, 1'b1, pcv, rr, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic idle(input bit rr);
        step(1'b1, 1'b0, 32'd0, rr, 1'b0, '0, 1'b0, '0);
    endtask

    // Monitor: sample mid-cycle, pop on each take.
    always @(posedge clk) begin
        if (mon_en) begin
            if (!reset) begin
                rd_cnt = wr_cnt;
            end else begin
                chk("req_ready", 64'(req_ready), 64'(exp_req_ready));
                chk("resp_valid", 64'(resp_valid), 64'(exp_resp_valid));
                chk("load_ptr", 64'(load_ptr), 64'(exp_ptr));
                if (exp_post_rst) begin
                    chk("rst_IR", 64'(IR), 64'd0);
                    chk("rst_err", 64'(resp_err), 64'd0);
                end
                if (resp_valid) begin
                    if (rd_cnt == wr_cnt) begin
                        chk("resp_unexpected", 64'(resp_valid), 64'd0);
                    end else begin
                        chk("IR", 64'(IR), 64'(exp_q[rd_cnt % QLEN][DATA_W-1:0]));
                        chk("resp_err", 64'(resp_err), 64'(exp_q[rd_cnt % QLEN][DATA_W]));
                        if (resp_ready) rd_cnt++;
                    end
                end
                if (end_chk) chk("pending_left", 64'(wr_cnt - rd_cnt), 64'd0);
            end
        end
    end

    initial begin
        logic [31:0]       pcv;
        logic [DATA_W-1:0] rd;
        int unsigned       r;
        n_cmp = 0; n_bad = 0; rd_cnt = 0; wr_cnt = 0;
        mdl_full = 1'b0; mdl_ptr = 0; mon_en = 1'b0; end_chk = 1'b0;
        prev_rst = 1'b0; exp_post_rst = 1'b0;
        exp_req_ready = 1'b1; exp_resp_valid = 1'b0; exp_ptr = '0;
        reset = 1'b0; req_valid = 1'b0; pc = '0; resp_ready = 1'b0;
        load_start = 1'b0; load_addr = '0; load_valid = 1'b0; load_data = '0;

        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, '0, 1'b0, '0);
        mon_en = 1'b1;
        step(1'b0, 1'b1, 32'd4, 1'b1, 1'b1, '1, 1'b1, '1);
        idle(1'b1);

        // Boot image, back-to-back
        fetch(32'd0, 1'b1);
        fetch(32'd4, 1'b1);
        fetch(32'd28, 1'b1);
        idle(1'b1);

        // Stall with a pending request, then release
        fetch(32'd4, 1'b1);
        repeat (3) fetch(32'd8, 1'b0);
        fetch(32'd8, 1'b1);
        idle(1'b1);

        // Load burst wrapping past the top of memory
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, AW'(DEPTH - 2), 1'b0, '0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, '0, 1'b1, DATA_W'(32'hAAAA0001));
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, '0, 1'b1, DATA_W'(32'hAAAA0002));
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, '0, 1'b1, DATA_W'(32'hAAAA0003));
        fetch(32'd0, 1'b1);
        fetch(32'((DEPTH - 1) * 4), 1'b1);

        // Same-edge load and fetch of word 5
        step(1'b1, 1'b1, 32'd20, 1'b1, 1'b1, AW'(5), 1'b1, DATA_W'(32'h12345678));

        // Error boundaries
        fetch(32'd2, 1'b1);
        fetch(32'(DEPTH * 4), 1'b1);
        fetch(32'(DEPTH * 4 - 4), 1'b1);
        fetch(32'h8000_0000, 1'b1);
        idle(1'b1);

        // Reset while FULL and mid load burst
        fetch(32'd4, 1'b0);
        step(1'b1, 1'b1, 32'd0, 1'b0, 1'b1, '0, 1'b1, DATA_W'(32'hBEEF0000));
        step(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, '0, 1'b1, DATA_W'(32'hBEEF0001));
        step(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, '0, 1'b1, DATA_W'(32'hBEEF0002));
        fetch(32'd0, 1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       pcv = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 6) pcv = 32'(4 * mdl_ptr);
            else if (r == 7) pcv = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else if (r == 8) pcv = 32'(DEPTH * 4 + 4 * $urandom_range(0, 3));
            else             pcv = $urandom;
            rd = DATA_W'({$urandom, $urandom});
            step($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0, pcv,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                 AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 2) == 0, rd);
        end

        // Drain and confirm nothing was lost
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        end_chk = 1'b1;
        idle(1'b1);
        @(posedge clk);
        #1;
        end_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
